// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle RV32I datapath: sequences fetch, decode, execute, memory and writeback,
// drives the datapath selects from the current instruction, and counts retired instructions.
module multicycle_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       Inst,
  input  logic              mem_ready,
  input  logic              BrEq,
  input  logic              BrLT,
  output logic              mem_req,
  output logic              MemRW,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              RegWEn,
  output logic              PCSel,
  output logic [2:0]        ImmSel,
  output logic              ASel,
  output logic              BSel,
  output logic              BrUn,
  output logic [1:0]        WBSel,
  output logic              halted,
  output logic [DATA_W-1:0] instret
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] instret_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_load, is_store;
  logic       is_opimm, is_op, is_branch, is_jump, legal, taken;

  logic mem_req_c, memrw_c, irwrite_c, pcwrite_c, regwen_c, pcsel_c;

  logic unused_inst;
  assign unused_inst = ^{Inst[31:15], Inst[11:7]};

  assign opcode = Inst[6:0];
  assign funct3 = Inst[14:12];

  always_comb begin
    is_lui    = (opcode == OPC_LUI);
    is_auipc  = (opcode == OPC_AUIPC);
    is_jal    = (opcode == OPC_JAL);
    is_jalr   = (opcode == OPC_JALR);
    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    is_opimm  = (opcode == OPC_OPIMM);
    is_op     = (opcode == OPC_OP);
    is_branch = (opcode == OPC_BRANCH);
    is_jump   = is_jal | is_jalr;
    // funct3 010/011 are unassigned branch encodings and trap like any unknown opcode
    legal     = is_lui | is_auipc | is_jump | is_load | is_store | is_opimm | is_op |
                (is_branch & (funct3[2:1] != 2'b01));
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = BrEq;
      3'b001:         taken = ~BrEq;
      3'b100, 3'b110: taken = BrLT;
      3'b101, 3'b111: taken = ~BrLT;
      default:        taken = 1'b0;
    endcase
  end

  // Datapath selects follow the instruction register in every state
  always_comb begin
    ImmSel = IMM_I;
    if (is_store)                ImmSel = IMM_S;
    else if (is_branch)          ImmSel = IMM_B;
    else if (is_jal)             ImmSel = IMM_J;
    else if (is_lui | is_auipc)  ImmSel = IMM_U;
    ASel  = is_auipc | is_jal | is_branch;
    BSel  = ~is_op;
    BrUn  = is_branch & funct3[1];
    WBSel = is_load ? 2'd0 : (is_jump ? 2'd2 : 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_req_c = 1'b0;
    memrw_c   = 1'b0;
    irwrite_c = 1'b0;
    pcwrite_c = 1'b0;
    regwen_c  = 1'b0;
    pcsel_c   = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          irwrite_c = 1'b1;
          state_d   = DECODE;
        end
      end
      DECODE: state_d = legal ? EXEC : HALT;
      EXEC: begin
        if (is_branch) begin
          pcwrite_c = 1'b1;
          pcsel_c   = taken;
          state_d   = FETCH;
        end else if (is_load | is_store) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_req_c = 1'b1;
        memrw_c   = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pcwrite_c = 1'b1;
            state_d   = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        regwen_c  = 1'b1;
        pcwrite_c = 1'b1;
        pcsel_c   = is_jump;
        state_d   = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Reset forces FETCH, whose mem_req would otherwise be high; gating keeps the bus quiet during reset
  assign mem_req = rst_n & mem_req_c;
  assign MemRW   = rst_n & memrw_c;
  assign IRWrite = rst_n & irwrite_c;
  assign PCWrite = rst_n & pcwrite_c;
  assign RegWEn  = rst_n & regwen_c;
  assign PCSel   = pcsel_c;
  assign halted  = (state_q == HALT);

  // Every retirement path is marked by exactly one PCWrite pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         instret_q <= '0;
    else if (pcwrite_c) instret_q <= instret_q + DATA_W'(1);
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of instructions with expected retire behaviour fed through a
// scoreboard queue, plus hand sequences for halt, reset mid-transaction and illegal branches.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Inst;
  logic        mem_ready, BrEq, BrLT;
  logic        mem_req, MemRW, IRWrite, PCWrite, RegWEn, PCSel;
  logic [2:0]  ImmSel;
  logic        ASel, BSel, BrUn;
  logic [1:0]  WBSel;
  logic        halted;
  logic [31:0] instret;

  multicycle_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Inst(Inst), .mem_ready(mem_ready), .BrEq(BrEq), .BrLT(BrLT),
    .mem_req(mem_req), .MemRW(MemRW), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWEn(RegWEn),
    .PCSel(PCSel), .ImmSel(ImmSel), .ASel(ASel), .BSel(BSel), .BrUn(BrUn), .WBSel(WBSel),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        breq, brlt;
    int          fwait, mwait;
    int          cycles, mreq_cyc, memw_cyc;
    logic        pcsel, regwen;
    logic [1:0]  wbsel;
    logic [2:0]  immsel;
    logic        asel, bsel, brun;
  } vec_t;

  vec_t        tbl[18];
  vec_t        sb[$];
  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] exp_instret = 0;

  function automatic vec_t mk(logic [31:0] inst, logic breq, logic brlt, int fw, int mw,
                              int cyc, int mreq, int mwr, logic pcsel, logic regwen,
                              logic [1:0] wbsel, logic [2:0] imm, logic asel, logic bsel,
                              logic brun);
    vec_t v;
    v.inst = inst; v.breq = breq; v.brlt = brlt; v.fwait = fw; v.mwait = mw;
    v.cycles = cyc; v.mreq_cyc = mreq; v.memw_cyc = mwr; v.pcsel = pcsel; v.regwen = regwen;
    v.wbsel = wbsel; v.immsel = imm; v.asel = asel; v.bsel = bsel; v.brun = brun;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Starts one cycle after a rising edge with the FSM in FETCH; returns in the same phase.
  task automatic run_instr(input int idx, input vec_t v);
    vec_t e;
    int   cyc = 0, mreq = 0, mw = 0, irw = 0, rwe = 0, reqidx = 0, waitcnt = 0;
    bit   done = 0;
    sb.push_back(v);
    Inst = v.inst;
    BrEq = v.breq;
    BrLT = v.brlt;
    while (!done && cyc < 40) begin
      mem_ready = (waitcnt >= ((reqidx == 0) ? v.fwait : v.mwait));
      #2;
      cyc++;
      if (IRWrite) irw++;
      if (RegWEn) rwe++;
      if (mem_req) begin
        mreq++;
        if (MemRW) mw++;
        if (mem_ready) begin
          reqidx++;
          waitcnt = 0;
        end else begin
          waitcnt++;
        end
      end
      if (PCWrite) begin
        done = 1;
        e = sb.pop_front();
        chk($sformatf("v%0d cycles", idx), cyc, e.cycles);
        chk($sformatf("v%0d PCSel", idx), PCSel, e.pcsel);
        chk($sformatf("v%0d RegWEn", idx), rwe, e.regwen ? 1 : 0);
        if (e.regwen) chk($sformatf("v%0d WBSel", idx), WBSel, e.wbsel);
        chk($sformatf("v%0d ImmSel", idx), ImmSel, e.immsel);
        chk($sformatf("v%0d ASel", idx), ASel, e.asel);
        chk($sformatf("v%0d BSel", idx), BSel, e.bsel);
        chk($sformatf("v%0d BrUn", idx), BrUn, e.brun);
        chk($sformatf("v%0d mem_req cycles", idx), mreq, e.mreq_cyc);
        chk($sformatf("v%0d MemRW cycles", idx), mw, e.memw_cyc);
        chk($sformatf("v%0d IRWrite pulses", idx), irw, 1);
        chk($sformatf("v%0d halted", idx), halted, 0);
      end
      next_cyc();
    end
    if (!done) begin
      chk($sformatf("v%0d retire timeout", idx), 0, 1);
      void'(sb.pop_front());
    end
    exp_instret++;
    chk($sformatf("v%0d instret", idx), instret, exp_instret);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("reset halted", halted, 0);
    chk("reset mem_req", mem_req, 0);
    chk("reset instret", instret, 0);
    exp_instret = 0;
    next_cyc();
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #2;
    chk("post-reset mem_req", mem_req, 1);
    chk("post-reset MemRW", MemRW, 0);
    next_cyc();
  endtask

  initial begin
    int hcnt, scnt;
    //        inst          eq lt fw mw cyc mrq mw  pcs rwe wb imm a  b  u
    tbl[0]  = mk(32'h00a10093, 0, 0, 0, 0, 4, 1, 0, 0, 1, 1, 0, 0, 1, 0); // ADDI
    tbl[1]  = mk(32'h00012083, 0, 0, 0, 0, 5, 2, 0, 0, 1, 0, 0, 0, 1, 0); // LW
    tbl[2]  = mk(32'h00112023, 0, 0, 0, 0, 4, 2, 1, 0, 0, 1, 1, 0, 1, 0); // SW
    tbl[3]  = mk(32'h00209463, 1, 0, 0, 0, 3, 1, 0, 0, 0, 1, 2, 1, 1, 0); // BNE eq
    tbl[4]  = mk(32'h00209463, 0, 0, 0, 0, 3, 1, 0, 1, 0, 1, 2, 1, 1, 0); // BNE ne
    tbl[5]  = mk(32'h00208463, 1, 0, 0, 0, 3, 1, 0, 1, 0, 1, 2, 1, 1, 0); // BEQ
    tbl[6]  = mk(32'h0020c463, 0, 1, 0, 0, 3, 1, 0, 1, 0, 1, 2, 1, 1, 0); // BLT
    tbl[7]  = mk(32'h0020d463, 0, 1, 0, 0, 3, 1, 0, 0, 0, 1, 2, 1, 1, 0); // BGE
    tbl[8]  = mk(32'h0020f463, 0, 0, 0, 0, 3, 1, 0, 1, 0, 1, 2, 1, 1, 1); // BGEU
    tbl[9]  = mk(32'h0020e463, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 2, 1, 1, 1); // BLTU
    tbl[10] = mk(32'h064000ef, 0, 0, 0, 0, 4, 1, 0, 1, 1, 2, 3, 1, 1, 0); // JAL
    tbl[11] = mk(32'h000080e7, 0, 0, 0, 0, 4, 1, 0, 1, 1, 2, 0, 0, 1, 0); // JALR
    tbl[12] = mk(32'h123450b7, 0, 0, 0, 0, 4, 1, 0, 0, 1, 1, 4, 0, 1, 0); // LUI
    tbl[13] = mk(32'h00001097, 0, 0, 0, 0, 4, 1, 0, 0, 1, 1, 4, 1, 1, 0); // AUIPC
    tbl[14] = mk(32'h002081b3, 0, 0, 0, 0, 4, 1, 0, 0, 1, 1, 0, 0, 0, 0); // ADD
    tbl[15] = mk(32'h00a10093, 0, 0, 2, 0, 6, 3, 0, 0, 1, 1, 0, 0, 1, 0); // ADDI fetch wait
    tbl[16] = mk(32'h00012083, 0, 0, 0, 3, 8, 5, 0, 0, 1, 0, 0, 0, 1, 0); // LW mem wait 3
    tbl[17] = mk(32'h00112023, 0, 0, 1, 2, 7, 5, 3, 0, 0, 1, 1, 0, 1, 0); // SW both waits

    rst_n = 1'b0; mem_ready = 1'b1; Inst = 32'h00a10093; BrEq = 1'b0; BrLT = 1'b0;
    #3;
    chk("rst mem_req", mem_req, 0);
    chk("rst MemRW", MemRW, 0);
    chk("rst strobes", {IRWrite, PCWrite, RegWEn}, 0);
    chk("rst halted", halted, 0);
    chk("rst instret", instret, 0);
    next_cyc();
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #2;
    chk("first mem_req", mem_req, 1);
    next_cyc();

    for (int i = 0; i < 18; i++) run_instr(i, tbl[i]);

    // Reset arrives asynchronously while a store waits in MEM
    Inst = 32'h00112023; mem_ready = 1'b1;
    #2; next_cyc();
    mem_ready = 1'b0;
    next_cyc();
    next_cyc();
    #2;
    chk("sw mem_req in MEM", mem_req, 1);
    chk("sw MemRW in MEM", MemRW, 1);
    next_cyc();
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst mem_req", mem_req, 0);
    chk("async rst MemRW", MemRW, 0);
    chk("async rst PCWrite", PCWrite, 0);
    chk("async rst instret", instret, 0);
    exp_instret = 0;
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    run_instr(100, tbl[0]);

    // Unknown opcode parks the FSM in HALT until reset
    Inst = 32'h0000007f; mem_ready = 1'b1;
    #2;
    chk("illegal fetch IRWrite", IRWrite, 1);
    next_cyc();
    next_cyc();
    hcnt = 0; scnt = 0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (halted === 1'b1) hcnt++;
      if (IRWrite | PCWrite | RegWEn | mem_req | MemRW) scnt++;
      next_cyc();
    end
    chk("halt cycles", hcnt, 20);
    chk("halt strobe cycles", scnt, 0);
    chk("halt instret", instret, exp_instret);
    reset_pulse();
    run_instr(101, tbl[14]);

    // Branch with reserved funct3 010 halts as well
    Inst = 32'h0020a463; mem_ready = 1'b1;
    next_cyc();
    next_cyc();
    #2;
    chk("bad branch halted", halted, 1);
    chk("bad branch PCWrite", PCWrite, 0);
    next_cyc();
    reset_pulse();
    run_instr(102, tbl[8]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port Inst, input, 32, instruction register contents; stable from the cycle after IRWrite until the next IRWrite.
REQ-004 SHALL have port mem_ready, input, 1, memory completes the current request this cycle.
REQ-005 SHALL have ports BrEq and BrLT, input, 1 each, branch comparator results.
REQ-006 SHALL have port mem_req, output, 1, memory request, held until mem_ready.
REQ-007 SHALL have port MemRW, output, 1, 1 = write, 0 = read.
REQ-008 SHALL have ports IRWrite, PCWrite and RegWEn, output, 1 each, single-cycle write strobes.
REQ-009 SHALL have port PCSel, output, 1, 1 = ALU result, 0 = pc+4.
REQ-010 SHALL have ports ImmSel (3), ASel (1), BSel (1), BrUn (1) and WBSel (2), output, datapath selects.
REQ-011 SHALL have port halted, output, 1, illegal instruction seen; sticky.
REQ-012 SHALL have port instret, output, 32, count of retired instructions.

Function
REQ-013 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-014 SHALL in FETCH drive mem_req=1 and MemRW=0; while mem_ready=0 it SHALL stay in FETCH; on mem_ready=1 it SHALL pulse IRWrite=1 and go to DECODE.
REQ-015 SHALL in DECODE go to EXEC for opcodes LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, and BRANCH 1100011 with funct3 not 010/011.
REQ-016 SHALL in DECODE go to HALT for any other opcode and for BRANCH with funct3 010 or 011.
REQ-017 SHALL in EXEC, for BRANCH, set taken = BEQ:BrEq, BNE:!BrEq, BLT/BLTU:BrLT, BGE/BGEU:!BrLT.
REQ-018 SHALL in EXEC, for BRANCH, pulse PCWrite=1 with PCSel=taken, increment instret and go to FETCH.
REQ-019 SHALL in EXEC go to MEM for LOAD and STORE, and to WB for all other opcodes.
REQ-020 SHALL in MEM drive mem_req=1 and MemRW = 1 for STORE, 0 for LOAD, and stay in MEM while mem_ready=0.
REQ-021 SHALL in MEM on mem_ready=1 for STORE pulse PCWrite (PCSel=0), increment instret and go to FETCH.
REQ-022 SHALL in MEM on mem_ready=1 for LOAD go to WB.
REQ-023 SHALL in WB pulse RegWEn=1 and PCWrite=1, increment instret and go to FETCH.
REQ-024 SHALL in WB drive PCSel=1 for JAL/JALR, else 0.
REQ-025 SHALL in WB drive WBSel = 0 for LOAD, 2 for JAL/JALR, else 1.
REQ-026 SHALL drive ImmSel from opcode in every state: I=0 (LOAD, OP-IMM, JALR), S=1, B=2, J=3, U=4, OP=0.
REQ-027 SHALL drive ASel=1 for AUIPC, JAL and BRANCH, else 0.
REQ-028 SHALL drive BSel=0 for OP only, else 1.
REQ-029 SHALL drive BrUn = funct3[1] for BRANCH, else 0.
REQ-030 SHALL in HALT assert halted=1, keep all strobes and mem_req at 0, and leave only by reset.
REQ-031 SHALL keep IRWrite, PCWrite, RegWEn and mem_req at 0 in every state and condition not listed above.
REQ-032 SHALL make MemRW=1 only in MEM for STORE.
REQ-033 SHALL wrap instret from 0xFFFFFFFF to 0 with no flag.
REQ-034 SHALL take 4 cycles per instruction for ALU/jump/U-type, 3 for branch, 4 for store and 5 for load, with zero-wait memory.

Reset
REQ-035 SHALL on rst_n=0, in any state including mid-MEM with mem_req high, immediately force FETCH, halted=0, instret=0 and all strobes and mem_req to 0.
REQ-036 SHALL, after rst_n deasserts, assert mem_req in FETCH in the first cycle.

Verification
REQ-037 Zero-wait memory, ADDI 0x00a10093 -> states FETCH,DECODE,EXEC,WB; in WB RegWEn=1, WBSel=01, BSel=1, PCSel=0; instret=1.
REQ-038 LW 0x00012083, mem_ready low 3 cycles in MEM -> mem_req held 4 cycles with MemRW=0; WB has WBSel=00; 8 cycles total.
REQ-039 BNE funct3=001 with BrEq=1 -> in EXEC PCWrite=1, PCSel=0, BrUn=0; with BrEq=0 -> PCSel=1; BGEU with BrLT=0 -> PCSel=1, BrUn=1.
REQ-040 JAL 0x064000ef -> ImmSel=011, ASel=1; in WB WBSel=10, PCSel=1, RegWEn=1.
REQ-041 Inst 0x0000007f -> HALT, halted=1, no strobes for 20 cycles; then rst_n pulse -> halted=0, FETCH.
REQ-042 rst_n asserted during a SW MEM wait -> mem_req and MemRW drop without waiting for clk; instret=0.
